// File: rtl/int_ctrl8.sv
// Eight-source interrupt controller. Rising edges on the sources are latched as pending bits
// and presented one at a time through a request / acknowledge / end-of-interrupt handshake.
module int_ctrl8 #(
   parameter int PRIO_MODE = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] irq_in,
   input  logic       mask_we,
   input  logic [7:0] mask_in,
   input  logic       int_ack,
   input  logic       eoi,
   output logic       int_req,
   output logic [2:0] int_id,
   output logic       in_service,
   output logic [7:0] pending
);

   // Handshake: int_req stays high with int_id stable until int_ack (accept)
   // or until the presented source becomes masked (withdrawal).
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t     state;
   logic [7:0] irq_q;
   logic [7:0] mask;
   logic [7:0] eligible;
   logic [7:0] rise;
   logic [7:0] clr;
   logic [2:0] last;
   logic [2:0] base;
   logic [2:0] idx;
   logic [2:0] winner;
   logic       found;

   assign rise     = irq_in & ~irq_q;
   assign eligible = pending & ~mask;
   assign clr      = (state == REQ && int_ack) ? (8'd1 << int_id) : 8'd0;

   // A base of 0 makes the descending search 7..0, which is the fixed order.
   assign base = (PRIO_MODE != 0) ? last : 3'd0;

   always_comb begin
      winner = 3'd0;
      found  = 1'b0;
      idx    = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         idx = base - 3'(k);
         if (!found && eligible[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   // A new edge in the same cycle as the acknowledge clear keeps the bit set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q   <= 8'h00;
         mask    <= 8'h00;
         pending <= 8'h00;
      end else begin
         irq_q   <= irq_in;
         pending <= (pending & ~clr) | rise;
         if (mask_we)
            mask <= mask_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         int_req    <= 1'b0;
         int_id     <= 3'd0;
         in_service <= 1'b0;
         last       <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (eligible != 8'h00) begin
                  state   <= REQ;
                  int_id  <= winner;
                  int_req <= 1'b1;
               end
            end
            REQ: begin
               if (int_ack) begin
                  state      <= SERVICE;
                  int_req    <= 1'b0;
                  in_service <= 1'b1;
               end else if (!eligible[int_id]) begin
                  state   <= IDLE;
                  int_req <= 1'b0;
               end
            end
            SERVICE: begin
               if (eoi) begin
                  state      <= IDLE;
                  in_service <= 1'b0;
                  last       <= int_id;
               end
            end
            default: begin
               state      <= IDLE;
               int_req    <= 1'b0;
               in_service <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl8.sv
// Bench for int_ctrl8: a fixed-priority and a rotating-priority instance share all inputs
// and are compared every cycle against a behavioural model, plus directed scenario checks.
module tb_int_ctrl8;

   logic       clk;
   logic       rst;
   logic [7:0] irq_in;
   logic       mask_we;
   logic [7:0] mask_in;
   logic       int_ack;
   logic       eoi;
   logic       int_req0, int_req1;
   logic [2:0] int_id0, int_id1;
   logic       in_service0, in_service1;
   logic [7:0] pending0, pending1;

   int n_tests = 0;
   int n_fail  = 0;

   int_ctrl8 #(.PRIO_MODE(0)) dut_fix (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_in(mask_in),
      .int_ack(int_ack), .eoi(eoi), .int_req(int_req0), .int_id(int_id0),
      .in_service(in_service0), .pending(pending0)
   );

   int_ctrl8 #(.PRIO_MODE(1)) dut_rot (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_in(mask_in),
      .int_ack(int_ack), .eoi(eoi), .int_req(int_req1), .int_id(int_id1),
      .in_service(in_service1), .pending(pending1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model (index 0 = fixed, 1 = rotating) ----------------
   int         m_phase [2];   // 0 waiting, 1 presenting, 2 being serviced
   logic [7:0] m_pend  [2];
   logic [7:0] m_mask  [2];
   logic [7:0] m_prev  [2];
   logic [2:0] m_id    [2];
   logic [2:0] m_last  [2];
   logic       m_req   [2];
   logic       m_isv   [2];

   function automatic logic [2:0] pick(input logic [7:0] e, input bit rot, input logic [2:0] last);
      int order[$];
      if (!rot) begin
         for (int i = 7; i >= 0; i--) order.push_back(i);
      end else begin
         for (int k = 1; k <= 8; k++) order.push_back((int'(last) + 8 - k) % 8);
      end
      foreach (order[j])
         if (e[order[j]]) return 3'(order[j]);
      return 3'd0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = 0;
         m_pend[d]  = 8'h00;
         m_mask[d]  = 8'h00;
         m_prev[d]  = 8'h00;
         m_id[d]    = 3'd0;
         m_last[d]  = 3'd0;
         m_req[d]   = 1'b0;
         m_isv[d]   = 1'b0;
      end
   endtask

   task automatic model_update(input int d);
      logic [7:0] elig;
      logic [7:0] newly;
      logic [7:0] cleared;
      elig    = m_pend[d] & ~m_mask[d];
      newly   = irq_in & ~m_prev[d];
      cleared = 8'h00;
      if (m_phase[d] == 0) begin
         if (elig != 8'h00) begin
            m_id[d]    = pick(elig, d == 1, m_last[d]);
            m_req[d]   = 1'b1;
            m_phase[d] = 1;
         end
      end else if (m_phase[d] == 1) begin
         if (int_ack) begin
            cleared[m_id[d]] = 1'b1;
            m_req[d]   = 1'b0;
            m_isv[d]   = 1'b1;
            m_phase[d] = 2;
         end else if (!elig[m_id[d]]) begin
            m_req[d]   = 1'b0;
            m_phase[d] = 0;
         end
      end else begin
         if (eoi) begin
            m_isv[d]   = 1'b0;
            m_last[d]  = m_id[d];
            m_phase[d] = 0;
         end
      end
      m_pend[d] = (m_pend[d] & ~cleared) | newly;
      if (mask_we) m_mask[d] = mask_in;
      m_prev[d] = irq_in;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("fix_req",  {7'd0, int_req0},    {7'd0, m_req[0]});
      check("fix_id",   {5'd0, int_id0},     {5'd0, m_id[0]});
      check("fix_isv",  {7'd0, in_service0}, {7'd0, m_isv[0]});
      check("fix_pend", pending0,            m_pend[0]);
      check("rot_req",  {7'd0, int_req1},    {7'd0, m_req[1]});
      check("rot_id",   {5'd0, int_id1},     {5'd0, m_id[1]});
      check("rot_isv",  {7'd0, in_service1}, {7'd0, m_isv[1]});
      check("rot_pend", pending1,            m_pend[1]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset();
      else begin
         model_update(0);
         model_update(1);
      end
      @(negedge clk);
      compare_all();
      int_ack = 1'b0;
      eoi     = 1'b0;
      mask_we = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      cycle();
      irq_in = 8'h00;
      rst    = 1'b0;
      cycle();
   endtask

   task automatic ack_eoi();
      int_ack = 1'b1;
      cycle();
      eoi = 1'b1;
      cycle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst     = 1'b1;
      irq_in  = 8'h00;
      mask_we = 1'b0;
      mask_in = 8'h00;
      int_ack = 1'b0;
      eoi     = 1'b0;
      model_reset();
      @(negedge clk);
      check("reset_req",  {7'd0, int_req0}, 8'h00);
      check("reset_pend", pending0,         8'h00);
      do_reset();

      // single source, full handshake
      irq_in = 8'h01;
      cycle();
      check("s1_pend", pending0, 8'h01);
      check("s1_req_early", {7'd0, int_req0}, 8'h00);
      cycle();
      check("s1_req", {7'd0, int_req0}, 8'h01);
      check("s1_id",  {5'd0, int_id0},  8'h00);
      int_ack = 1'b1;
      cycle();
      check("s1_isv",     {7'd0, in_service0}, 8'h01);
      check("s1_pend_ck", pending0,            8'h00);
      eoi = 1'b1;
      cycle();
      check("s1_isv_off", {7'd0, in_service0}, 8'h00);
      irq_in = 8'h00;
      cycle();

      // fixed priority ordering 7, 2, 0
      irq_in = 8'h85;
      cycle();
      cycle();
      check("fx_first", {5'd0, int_id0}, 8'h07);
      ack_eoi();
      cycle();
      check("fx_second", {5'd0, int_id0}, 8'h02);
      ack_eoi();
      cycle();
      check("fx_third", {5'd0, int_id0}, 8'h00);
      ack_eoi();
      cycle();

      // rotating: 7, 2, then 0 ahead of a re-raised 7
      do_reset();
      irq_in = 8'h85;
      cycle();
      cycle();
      check("rot_first", {5'd0, int_id1}, 8'h07);
      ack_eoi();
      cycle();
      check("rot_second", {5'd0, int_id1}, 8'h02);
      int_ack = 1'b1;
      cycle();
      irq_in = 8'h05;
      cycle();
      irq_in = 8'h85;
      cycle();
      eoi = 1'b1;
      cycle();
      cycle();
      check("rot_third", {5'd0, int_id1}, 8'h00);
      check("fx_prefers7", {5'd0, int_id0}, 8'h07);
      ack_eoi();
      cycle();
      check("rot_fourth", {5'd0, int_id1}, 8'h07);
      ack_eoi();
      cycle();

      // masking withdraws the request without losing the pending bit
      do_reset();
      irq_in = 8'h80;
      cycle();
      cycle();
      mask_we = 1'b1;
      mask_in = 8'h80;
      cycle();
      cycle();
      check("mask_drop", {7'd0, int_req0}, 8'h00);
      check("mask_pend", pending0,         8'h80);
      mask_we = 1'b1;
      mask_in = 8'h00;
      cycle();
      cycle();
      check("unmask_req", {7'd0, int_req0}, 8'h01);
      check("unmask_id",  {5'd0, int_id0},  8'h07);
      ack_eoi();

      // new edge coinciding with the acknowledge clear
      do_reset();
      irq_in = 8'h08;
      cycle();
      cycle();
      irq_in = 8'h00;
      cycle();
      irq_in  = 8'h08;
      int_ack = 1'b1;
      cycle();
      check("sc_pend", pending0,            8'h08);
      check("sc_isv",  {7'd0, in_service0}, 8'h01);
      eoi = 1'b1;
      cycle();
      cycle();
      check("sc_rereq", {5'd0, int_id0}, 8'h03);
      ack_eoi();

      // asynchronous reset in the middle of service
      do_reset();
      irq_in = 8'h10;
      cycle();
      cycle();
      int_ack = 1'b1;
      cycle();
      #2 rst = 1'b1;
      #1;
      check("ar_isv",  {7'd0, in_service0}, 8'h00);
      check("ar_req",  {7'd0, int_req0},    8'h00);
      check("ar_id",   {5'd0, int_id0},     8'h00);
      check("ar_pend", pending0,            8'h00);
      model_reset();
      cycle();
      rst = 1'b0;
      eoi = 1'b1;
      cycle();
      check("ar_edge_pend", pending0,            8'h10);
      check("ar_eoi_ign",   {7'd0, in_service0}, 8'h00);
      cycle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 8; b++)
            if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
         if ($urandom_range(0, 15) == 0) begin
            mask_we = 1'b1;
            mask_in = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
         end
         int_ack = ($urandom_range(0, 2) == 0);
         eoi     = ($urandom_range(0, 3) == 0);
         rst     = ($urandom_range(0, 400) == 0);
         cycle();
      end
      rst = 1'b0;
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/int_ctrl8.md
INT_CTRL8 -- requirements
Module: int_ctrl8

Interface
REQ-001 Parameter PRIO_MODE, default 0, SHALL select 0 = fixed priority (bit 7 highest, bit 0 lowest) or 1 = rotating priority.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 irq_in  input  8  interrupt sources, synchronous to clk, rising-edge triggered.
REQ-005 mask_we  input  1  mask write strobe.
REQ-006 mask_in  input  8  new mask value; bit=1 disables that source.
REQ-007 int_ack  input  1  CPU acknowledge of the presented request.
REQ-008 eoi  input  1  end-of-interrupt from CPU.
REQ-009 int_req  output  1  interrupt request to CPU.
REQ-010 int_id  output  3  encoded index of the requested or in-service source.
REQ-011 in_service  output  1  high while a source is being serviced.
REQ-012 pending  output  8  latched pending bits, unmasked view.

Function
REQ-013 The block SHALL register irq_in each cycle (irq_q) and set pending[i] when irq_in[i]=1 and irq_q[i]=0.
REQ-014 mask SHALL load mask_in on a clock edge with mask_we=1 and hold otherwise; masking SHALL NOT clear pending.
REQ-015 Eligible set SHALL be pending & ~mask.
REQ-016 FSM states SHALL be IDLE, REQ, SERVICE.
REQ-017 IDLE: if eligible nonzero, next state REQ, int_id loaded with the priority winner, int_req=1 from the next cycle; else stay.
REQ-018 REQ: int_req held 1 and int_id held stable until int_ack=1 or withdrawal.
REQ-019 REQ with int_ack=1: clear pending[int_id], int_req=0, in_service=1, next state SERVICE; int_id unchanged.
REQ-020 REQ with eligible[int_id]=0 (source masked) and int_ack=0: int_req=0, next state IDLE (withdrawal); no pending bit cleared.
REQ-021 SERVICE: on eoi=1, in_service=0, next state IDLE; last-served pointer updated to int_id.
REQ-022 int_ack outside REQ and eoi outside SERVICE SHALL be ignored.
REQ-023 Fixed mode: winner = highest set index of eligible.
REQ-024 Rotating mode: search order SHALL be (last-1), (last-2), ... wrapping mod 8, ending at last; last resets to 0, so the post-reset order equals fixed order.
REQ-025 New edge on source i in the same cycle as its ack-clear: set SHALL win (pending[i]=1 after the edge).
REQ-026 Edges on any source SHALL latch in every state, including SERVICE; no nesting, one source in service at a time.
REQ-027 Latency: irq_in[i] first sampled high at edge n (IDLE, unmasked, sole source) -> pending[i]=1 after n, int_req=1 after n+1.
REQ-028 int_id SHALL hold its last value in IDLE.

Reset
REQ-029 rst=1 SHALL asynchronously force: state IDLE, int_req=0, int_id=0, in_service=0, pending=0, mask=8'h00, irq_q=0, last=0.
REQ-030 Source held high across reset release SHALL register one edge at the first clock after release.
REQ-031 Reset during REQ or SERVICE SHALL abandon the transaction with no residual pending or in_service.

Verification
REQ-032 PRIO_MODE=0, irq_in 00000000->00000001 -> pending=01, int_req=1 two edges later, int_id=0; int_ack -> in_service=1, pending=00; eoi -> IDLE, in_service=0.
REQ-033 Fixed: simultaneous edges 00000000->10000101 -> int_id=7 first; after ack+eoi, int_id=2, then int_id=0.
REQ-034 Rotating: pending 10000101, serve 7 -> next int_id=2; re-raise 7 while serving 2 -> next int_id=0 (order 1,0,7), then 7.
REQ-035 Masking: mask_we with mask_in=8'h80 while in REQ with int_id=7 -> int_req drops next cycle, IDLE, pending[7] still 1; unmask -> int_req=1 with int_id=7.
REQ-036 Set-vs-clear: falling then rising edge on source 3 timed to coincide with int_ack for id 3 -> pending[3]=1 after ack; re-request int_id=3 after eoi.
REQ-037 Assert rst mid-SERVICE -> all outputs 0 immediately without a clock edge; eoi after release ignored.
